pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Merges stall requests from the IF, ID, EXE and MEM stages into the shared 6-bit stall vector: [0]=pc, [1]=if, [2]=id, [3]=exe, [4]=mem, [5]=wb.
- Sequences exception/ERET flushes with the flush target PC.
- Tracks an outstanding data-memory transaction, deferring flushes and timing out a hung bus.
- Drives the stall and flush inputs of every pipeline register, including mem/wb.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 46 ++++
 rtl/pipe_hazard_ctrl_wait.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stall vector bit order: [0]=pc [1]=if [2]=id [3]=exe [4]=mem [5]=wb.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EXE = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF  = 6'b000011;
    localparam logic [STALL_W-1:0] NOSTALL   = 6'b000000;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_D_WAIT     = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } hz_state_e;

    // Exception held back while a data access is outstanding.
    typedef struct packed {
        logic              valid;
        logic              eret;
        logic [ADDR_W-1:0] epc;
    } exc_pend_t;

    // Deepest requesting stage wins; everything upstream of it freezes too.
    function automatic logic [STALL_W-1:0] stall_encode(
        input logic mem_req,
        input logic exe_req,
        input logic id_req,
        input logic if_req
    );
        if (mem_req == STOP)      return STALL_MEM;
        else if (exe_req == STOP) return STALL_EXE;
        else if (id_req == STOP)  return STALL_ID;
        else if (if_req == STOP)  return STALL_IF;
        else                      return NOSTALL;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_wait.sv
// Outstanding data-access wait counter with saturating timeout compare.
module dmem_wait_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clear_i,
    output logic wait_active_o,
    output logic timeout_hit_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter starts at 1 on the request cycle and stops at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (clear_i) begin
            cnt_d = '0;
        end else if ((cnt_q != '0) && (cnt_q < TIMEOUT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wait_active_o = (cnt_q != '0);
    assign timeout_hit_o = (cnt_q == TIMEOUT_C);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges stage stall
// requests, sequences exception/ERET flushes, defers them behind data accesses.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic                 if_stallreq,
    input  logic                 id_stallreq,
    input  logic                 exe_stallreq,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    input  logic                 exc_valid,
    input  logic                 exc_eret,
    input  logic [ADDR_W-1:0]    cp0_epc,
    output logic [STALL_W-1:0]   stall,
    output logic                 flush,
    output logic [ADDR_W-1:0]    flush_pc,
    output logic                 dmem_timeout,
    output logic                 busy_wait
);

    hz_state_e          state_q;
    hz_state_e          state_d;
    exc_pend_t          pend_q;
    exc_pend_t          pend_d;

    logic               mem_req_c;
    logic               wait_active;
    logic               timeout_hit;
    logic               trk_load;
    logic               trk_clear;
    logic               wait_done_c;

    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic [ADDR_W-1:0]  flush_pc_c;
    logic               timeout_c;

    assign mem_req_c = dmem_req & ~dmem_ack;

    dmem_wait_tracker #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait (
        .clk_i         (cpu_clk_50M),
        .rst_i         (cpu_rst),
        .load_i        (trk_load),
        .clear_i       (trk_clear),
        .wait_active_o (wait_active),
        .timeout_hit_o (timeout_hit)
    );

    // A lost counter (never expected) also ends the wait instead of hanging.
    assign wait_done_c = dmem_ack | timeout_hit | ~wait_active;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        stall_c    = NOSTALL;
        flush_c    = 1'b0;
        flush_pc_c = '0;
        timeout_c  = 1'b0;
        trk_load   = 1'b0;
        trk_clear  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_valid && !mem_req_c) begin
                    flush_c    = 1'b1;
                    flush_pc_c = exc_eret ? cp0_epc : EXC_VECTOR;
                end else begin
                    stall_c = stall_encode(mem_req_c, exe_stallreq,
                                           id_stallreq, if_stallreq);
                    if (mem_req_c) begin
                        state_d  = ST_D_WAIT;
                        trk_load = 1'b1;
                        if (exc_valid) begin
                            pend_d.valid = 1'b1;
                            pend_d.eret  = exc_eret;
                            pend_d.epc   = cp0_epc;
                        end
                    end
                end
            end

            ST_D_WAIT: begin
                stall_c = STALL_MEM;
                // First exception to arrive is kept; later ones are ignored.
                if (exc_valid && !pend_q.valid) begin
                    pend_d.valid = 1'b1;
                    pend_d.eret  = exc_eret;
                    pend_d.epc   = cp0_epc;
                end
                if (wait_done_c) begin
                    stall_c   = NOSTALL;
                    timeout_c = timeout_hit & ~dmem_ack;
                    trk_clear = 1'b1;
                    state_d   = pend_d.valid ? ST_FLUSH_PEND : ST_RUN;
                end
            end

            ST_FLUSH_PEND: begin
                flush_c    = 1'b1;
                flush_pc_c = pend_q.eret ? pend_q.epc : EXC_VECTOR;
                pend_d     = '0;
                state_d    = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= ST_RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs are held at zero for the whole reset window.
    assign stall        = cpu_rst ? NOSTALL : stall_c;
    assign flush        = ~cpu_rst & flush_c;
    assign flush_pc     = cpu_rst ? '0 : flush_pc_c;
    assign dmem_timeout = ~cpu_rst & timeout_c;
    assign busy_wait    = ~cpu_rst & (state_q == ST_D_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        logic        busy;
    } exp_t;

    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
    localparam logic [5:0]  S_MEM   = 6'b011111;

    logic        clk;
    logic        rst;
    logic        if_req, id_req, exe_req;
    logic        req, ack;
    logic        exv, eret;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        dmem_timeout;
    logic        busy_wait;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_assert;
    int    n_fail;

    pipe_hazard_ctrl #(
        .EXC_VECTOR (EXC_VEC),
        .TIMEOUT    (4),
        .CNT_W      (8)
    ) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (rst),
        .if_stallreq  (if_req),
        .id_stallreq  (id_req),
        .exe_stallreq (exe_req),
        .dmem_req     (req),
        .dmem_ack     (ack),
        .exc_valid    (exv),
        .exc_eret     (eret),
        .cp0_epc      (epc),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .dmem_timeout (dmem_timeout),
        .busy_wait    (busy_wait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs just after posedge and queue the expected outputs.
    task automatic vec(input string nm,
                       input logic r, input logic fi, input logic fd, input logic fe,
                       input logic rq, input logic ak, input logic xv, input logic xe,
                       input logic [31:0] xp,
                       input logic [5:0] e_st, input logic e_fl, input logic [31:0] e_pc,
                       input logic e_to, input logic e_bw);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_req = fi; id_req = fd; exe_req = fe;
        req = rq; ack = ak; exv = xv; eret = xe; epc = xp;
        e.stall = e_st; e.flush = e_fl; e.pc = e_pc; e.to = e_to; e.busy = e_bw;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got.stall = stall; got.flush = flush; got.pc = flush_pc;
                got.to = dmem_timeout; got.busy = busy_wait;
                n_assert++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got stall=%b flush=%b pc=%h to=%b busy=%b, want stall=%b flush=%b pc=%h to=%b busy=%b",
                             nm, got.stall, got.flush, got.pc, got.to, got.busy,
                             e.stall, e.flush, e.pc, e.to, e.busy);
                end
            end
        end
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; if_req = 0; id_req = 0; exe_req = 0;
        req = 0; ack = 0; exv = 0; eret = 0; epc = '0;

        //   name          rst if id ex rq ak xv xe epc            stall    fl pc            to bw
        vec("reset0",       1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        vec("reset_busy",   1, 1, 1, 1, 1, 0, 1, 1, 32'h1234_5678, 6'h00,   0, 32'h0,        0, 0);
        vec("idle",         0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // stall priority
        vec("id_exe",       0, 0, 1, 1, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h0,      0, 0);
        vec("id_only",      0, 0, 1, 0, 0, 0, 0, 0, 32'h0,         6'b000111, 0, 32'h0,      0, 0);
        vec("if_only",      0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         6'b000011, 0, 32'h0,      0, 0);
        vec("all_but_mem",  0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         6'b001111, 0, 32'h0,      0, 0);
        // zero-wait access
        vec("zw_req_ack",   0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        vec("zw_after",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // immediate flushes in RUN beat any stall request
        vec("run_exc",      0, 0, 1, 0, 0, 0, 1, 0, 32'hAAAA_0000, 6'h00,   1, EXC_VEC,      0, 0);
        vec("run_eret",     0, 1, 0, 1, 0, 0, 1, 1, 32'h1111_0000, 6'h00,   1, 32'h1111_0000, 0, 0);
        vec("run_post",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // 3-cycle wait
        vec("w3_c0",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 0);
        vec("w3_c1",        0, 0, 1, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 1);
        vec("w3_c2",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 1);
        vec("w3_ack",       0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 1);
        vec("w3_run",       0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // deferred ERET; second exception ignored; ack coincides with counter==TIMEOUT
        vec("de_c0",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 0);
        vec("de_c1_exc",    0, 0, 0, 0, 1, 0, 1, 1, 32'h8000_1234, S_MEM,   0, 32'h0,        0, 1);
        vec("de_c2",        0, 0, 0, 0, 1, 0, 1, 1, 32'hDEAD_0000, S_MEM,   0, 32'h0,        0, 1);
        vec("de_c3",        0, 0, 0, 0, 1, 0, 1, 0, 32'hDEAD_0000, S_MEM,   0, 32'h0,        0, 1);
        vec("de_c4_ack",    0, 0, 0, 0, 1, 1, 1, 0, 32'hDEAD_0000, 6'h00,   0, 32'h0,        0, 1);
        vec("de_c5_flush",  0, 0, 1, 0, 0, 0, 0, 0, 32'h0,         6'h00,   1, 32'h8000_1234, 0, 0);
        vec("de_c6",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // timeout with TIMEOUT=4
        vec("to_c0",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 0);
        vec("to_c1",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 1);
        vec("to_c2",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 1);
        vec("to_c3",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 1);
        vec("to_c4_pulse",  0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        1, 1);
        vec("to_c5_run",    0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        // exception alongside a new stalled request is latched, not flushed
        vec("rl_c0",        0, 0, 0, 0, 1, 0, 1, 0, 32'h5555_0000, S_MEM,   0, 32'h0,        0, 0);
        vec("rl_c1_ack",    0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 1);
        vec("rl_c2_flush",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   1, EXC_VEC,      0, 0);
        // reset mid-wait with a pending exception
        vec("rw_c0",        0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 0);
        vec("rw_c1_exc",    0, 0, 0, 0, 1, 0, 1, 1, 32'h8000_5678, S_MEM,   0, 32'h0,        0, 1);
        vec("rw_c2_rst",    1, 0, 0, 0, 1, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        vec("rw_c3",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        vec("rw_c4",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);
        vec("rw_c5_req",    0, 0, 0, 0, 1, 0, 0, 0, 32'h0,         S_MEM,   0, 32'h0,        0, 0);
        vec("rw_c6_ack",    0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 1);
        vec("rw_c7",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         6'h00,   0, 32'h0,        0, 0);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
